l2_block_responder: RTL and testbench
=====================================

# l2_block_responder

L2-side responder for the instruction-cache refill interface. It accepts a block-address request from `INSTRUCTION_CACHE` and reads the 16 words of that block from a word-wide synchronous backing memory. It packs the words into one 512-bit line and returns the line over the data valid/ready handshake. It replaces the behavioural L2 emulator and sits between the instruction cache and the instruction RAM.

## Interface
- `WORD_SIZE`, 4: bytes per word; `WORD_WIDTH` = 32.
- `WORD_PER_BLOCK`, 16: words per line; `BLOCK_WIDTH` = 512.
- `BLOCK_ADDRESS_WIDTH`, 26: width of the block address from the cache.
- `MEM_ADDRESS_WIDTH`, 10: word-address width of the backing memory.

- `CLK` in 1: single clock; all logic acts on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE` in 1: request valid.
- `ADDRESS_TO_L2_INSTRUCTION_CACHE` in 26: requested block address.
- `ADDRESS_TO_L2_READY_INSTRUCTION_CACHE` out 1: responder can accept a request.
- `DATA_FROM_L2_VALID_INSTRUCTION_CACHE` out 1: line valid.
- `DATA_FROM_L2_INSTRUCTION_CACHE` out 512: returned line.
- `DATA_FROM_L2_READY_INSTRUCTION_CACHE` in 1: cache accepts the line.
- `MEM_RD_EN` out 1: backing-memory read strobe.
- `MEM_ADDR` out `MEM_ADDRESS_WIDTH`: word address.
- `MEM_RD_DATA` in 32: read data, valid exactly one cycle after `MEM_RD_EN`.

## Operation
- FSM states: IDLE, FETCH, DRAIN, RESPOND.
- **IDLE**
  - `ADDRESS_TO_L2_READY` = 1, combinational from state.
  - On valid & ready: latch block address, clear word counter, go to FETCH.
- **FETCH**
  - `MEM_RD_EN` = 1 and `MEM_ADDR` = low `MEM_ADDRESS_WIDTH` bits of {block_addr, cnt[3:0]}; cnt increments each cycle.
  - After cnt = 15 is issued, go to DRAIN.
- **Capture pipeline**
  - A 1-cycle delayed copy of `MEM_RD_EN` qualifies capture of `MEM_RD_DATA`.
  - Word k lands in line bits [511−32k : 480−32k]: word 0 in the MSBs, word 15 in bits [31:0].
  - Implemented as a left-shifting assembly register.
- **DRAIN**
  - Captures word 15; sets `DATA_VALID` = 1 registered; go to RESPOND.
- **RESPOND**
  - `DATA_VALID` and `DATA` are held stable until `DATA_READY` = 1 at a clock edge; then clear `DATA_VALID` and go to IDLE.
- Only one request is outstanding. `ADDRESS_TO_L2_READY` = 0 in FETCH, DRAIN and RESPOND, so a request presented then waits.
- Address arithmetic:
  - Truncation of {block, cnt} to `MEM_ADDRESS_WIDTH` wraps modulo memory size; no error is flagged.
  - cnt is 4 bits, and its wrap from 15 to 0 is the FETCH exit condition.
- Reset, at any time including mid-FETCH or mid-RESPOND:
  - next state IDLE, cnt = 0, delayed read strobe = 0;
  - `DATA_VALID` = 0, `MEM_RD_EN` = 0, `MEM_ADDR` = 0, `DATA` = 0.
  - Any in-flight read data is discarded.
  - `ADDRESS_TO_L2_READY` = 1 from the first cycle after the reset edge.
  - A request presented while `RST` = 1 is not accepted.

## Timing
- Accept edge E0.
- Reads for words 0..15 are issued in the cycles following E0..E15.
- Captures happen at E2..E17.
- `DATA_VALID` is visible after E17, i.e. 17 cycles after accept.
- The handshake edge Eh moves the FSM to IDLE; the next request can be accepted at Eh+1.
- Minimum request-to-request spacing is 19 cycles.
- `DATA_READY` may be held high permanently; the line is then consumed at the first edge after `DATA_VALID` rises.
- `DATA_READY` while `DATA_VALID` = 0 is ignored.

## Structure
- Package `l2_pkg`:
  - widths: `WORD_WIDTH`, `BLOCK_WIDTH`, `BLOCK_ADDRESS_WIDTH`;
  - `WORD_PER_BLOCK` and its log2 (4);
  - FSM state encoding (2-bit localparams).
- Sub-module `l2_block_assembler`:
  - 512-bit shift register with capture enable and synchronous clear;
  - contains the capture-pipeline flop.
- Top level holds the FSM, counter, address formation and handshake.

## Test plan
- **Basic fetch.** Reset, memory[n] = 32'h1000_0000+n, request block 0 → `MEM_ADDR` 0..15 on consecutive cycles; `DATA_VALID` 17 cycles after accept; `DATA`[511:480] = 32'h1000_0000, `DATA`[31:0] = 32'h1000_000F.
- **Non-zero block.** Request block 3 → `MEM_ADDR` 48..63; `DATA`[511:480] = 32'h1000_0030.
- **Backpressure.** `DATA_READY` low for 5 cycles in RESPOND → `DATA`/`DATA_VALID` stable and `ADDRESS_TO_L2_READY` = 0 throughout; handshake completes on the first high `DATA_READY` edge.
- **Back-to-back.** Second request (block 1) held valid during RESPOND → accepted exactly one cycle after the data handshake; returned line matches block 1.
- **Reset mid-FETCH.** Assert `RST` after word 7 is issued → `MEM_RD_EN` = 0 and `DATA_VALID` never rises for that request; `ADDRESS_TO_L2_READY` = 1 the next cycle; a fresh block 2 request returns the correct line.
- **Wrap.** Request block 26'h3FF_FFFF with `MEM_ADDRESS_WIDTH` = 10 → `MEM_ADDR` 1008..1023; line equals memory[1008..1023].

Source files
------------

// File: rtl/l2_block_responder_pkg.sv
// Shared widths and FSM state type for the L2 instruction-refill responder.
package l2_pkg;
  localparam int unsigned WORD_SIZE           = 4;
  localparam int unsigned WORD_WIDTH          = 8 * WORD_SIZE;
  localparam int unsigned WORD_PER_BLOCK      = 16;
  localparam int unsigned WORD_IDX_WIDTH      = $clog2(WORD_PER_BLOCK);
  localparam int unsigned BLOCK_WIDTH         = WORD_WIDTH * WORD_PER_BLOCK;
  localparam int unsigned BLOCK_ADDRESS_WIDTH = 26;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DRAIN   = 2'd2,
    RESPOND = 2'd3
  } l2_state_e;
endpackage

// File: rtl/l2_block_responder_if.sv
// Cache-refill handshake plus backing-memory read port of the L2 responder.
interface l2_block_responder_if #(
  parameter int unsigned MEM_ADDRESS_WIDTH = 10
) ();
  import l2_pkg::*;

  logic                           ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE;
  logic [BLOCK_ADDRESS_WIDTH-1:0] ADDRESS_TO_L2_INSTRUCTION_CACHE;
  logic                           ADDRESS_TO_L2_READY_INSTRUCTION_CACHE;
  logic                           DATA_FROM_L2_VALID_INSTRUCTION_CACHE;
  logic [BLOCK_WIDTH-1:0]         DATA_FROM_L2_INSTRUCTION_CACHE;
  logic                           DATA_FROM_L2_READY_INSTRUCTION_CACHE;
  logic                           MEM_RD_EN;
  logic [MEM_ADDRESS_WIDTH-1:0]   MEM_ADDR;
  logic [WORD_WIDTH-1:0]          MEM_RD_DATA;

  modport slave (
    input  ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE,
    input  ADDRESS_TO_L2_INSTRUCTION_CACHE,
    output ADDRESS_TO_L2_READY_INSTRUCTION_CACHE,
    output DATA_FROM_L2_VALID_INSTRUCTION_CACHE,
    output DATA_FROM_L2_INSTRUCTION_CACHE,
    input  DATA_FROM_L2_READY_INSTRUCTION_CACHE,
    output MEM_RD_EN,
    output MEM_ADDR,
    input  MEM_RD_DATA
  );

  modport master (
    output ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE,
    output ADDRESS_TO_L2_INSTRUCTION_CACHE,
    input  ADDRESS_TO_L2_READY_INSTRUCTION_CACHE,
    input  DATA_FROM_L2_VALID_INSTRUCTION_CACHE,
    input  DATA_FROM_L2_INSTRUCTION_CACHE,
    output DATA_FROM_L2_READY_INSTRUCTION_CACHE,
    input  MEM_RD_EN,
    input  MEM_ADDR,
    output MEM_RD_DATA
  );
endinterface

// File: rtl/l2_block_responder_assembler.sv
// Packs 16 memory words into one line; word 0 ends up in the MSBs.
module l2_block_assembler
  import l2_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   rd_en,
  input  logic [WORD_WIDTH-1:0]  rd_data,
  output logic [BLOCK_WIDTH-1:0] line
);
  logic                   rd_en_q;
  logic [BLOCK_WIDTH-1:0] line_q;

  // Read data arrives one cycle after the strobe, so the delayed strobe qualifies capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_en_q <= 1'b0;
      line_q  <= '0;
    end else begin
      rd_en_q <= rd_en;
      if (rd_en_q)
        line_q <= {line_q[BLOCK_WIDTH-WORD_WIDTH-1:0], rd_data};
    end
  end

  assign line = line_q;
endmodule

// File: rtl/l2_block_responder.sv
// L2 responder: accepts a block address, reads 16 words, returns one 512-bit line.
module l2_block_responder
  import l2_pkg::*;
#(
  parameter int unsigned MEM_ADDRESS_WIDTH = 10
) (
  input logic                  CLK,
  input logic                  RST,
  l2_block_responder_if.slave  bus
);
  l2_state_e                      state_q, state_n;
  logic [WORD_IDX_WIDTH-1:0]      cnt_q;
  logic [BLOCK_ADDRESS_WIDTH-1:0] block_q;
  logic                           data_valid_q, data_valid_n;
  logic                           req_ready;
  logic                           rd_en;
  logic                           accept;
  logic [BLOCK_WIDTH-1:0]         line;

  assign accept = req_ready && bus.ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      block_q      <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_n;
      data_valid_q <= data_valid_n;
      if (accept) begin
        block_q <= bus.ADDRESS_TO_L2_INSTRUCTION_CACHE;
        cnt_q   <= '0;
      end else if (state_q == FETCH) begin
        cnt_q   <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_n      = state_q;
    data_valid_n = data_valid_q;
    req_ready    = 1'b0;
    rd_en        = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE)
          state_n = FETCH;
      end
      FETCH: begin
        rd_en = 1'b1;
        if (cnt_q == '1)
          state_n = DRAIN;
      end
      DRAIN: begin
        data_valid_n = 1'b1;
        state_n      = RESPOND;
      end
      RESPOND: begin
        if (bus.DATA_FROM_L2_READY_INSTRUCTION_CACHE) begin
          data_valid_n = 1'b0;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  l2_block_assembler u_assembler (
    .CLK     (CLK),
    .RST     (RST),
    .rd_en   (rd_en),
    .rd_data (bus.MEM_RD_DATA),
    .line    (line)
  );

  // Truncating {block, cnt} to the memory width wraps silently modulo memory size.
  assign bus.MEM_ADDR  = rd_en ? MEM_ADDRESS_WIDTH'({block_q, cnt_q}) : '0;
  assign bus.MEM_RD_EN = rd_en;
  assign bus.ADDRESS_TO_L2_READY_INSTRUCTION_CACHE = req_ready;
  assign bus.DATA_FROM_L2_VALID_INSTRUCTION_CACHE  = data_valid_q;
  assign bus.DATA_FROM_L2_INSTRUCTION_CACHE        = line;
endmodule

// File: tb/tb_l2_block_responder.sv
// Directed and randomized bench for l2_block_responder against a line-level memory model.
module tb_l2_block_responder;
  localparam int unsigned MAW   = 10;
  localparam int unsigned MSIZE = 1 << MAW;

  logic CLK;
  logic RST;
  logic [31:0] mem [MSIZE];
  logic [31:0] rd_data;
  int errors;
  int checks;

  l2_block_responder_if #(.MEM_ADDRESS_WIDTH(MAW)) bus ();

  l2_block_responder #(.MEM_ADDRESS_WIDTH(MAW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous backing memory: data one cycle after the strobe.
  always @(posedge CLK)
    if (bus.MEM_RD_EN) rd_data <= mem[bus.MEM_ADDR];
  assign bus.MEM_RD_DATA = rd_data;

  function automatic logic [MAW-1:0] model_addr(input logic [25:0] blk, input int k);
    longint unsigned a;
    a = (longint'(blk) * 16 + longint'(k)) % MSIZE;
    return a[MAW-1:0];
  endfunction

  function automatic logic [511:0] model_line(input logic [25:0] blk);
    logic [511:0] l;
    l = '0;
    for (int k = 0; k < 16; k++)
      l[511 - 32*k -: 32] = mem[model_addr(blk, k)];
    return l;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [25:0] blk);
    chk("req_ready_idle", bus.ADDRESS_TO_L2_READY_INSTRUCTION_CACHE, 1);
    bus.ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE = 1'b1;
    bus.ADDRESS_TO_L2_INSTRUCTION_CACHE       = blk;
    tick();
    bus.ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE = 1'b0;
  endtask

  // Starts in the first cycle after the accept edge; ends just after DATA_VALID rises.
  task automatic expect_fetch(input logic [25:0] blk);
    for (int k = 0; k < 16; k++) begin
      chk("fetch_rd_en", bus.MEM_RD_EN, 1);
      chk("fetch_addr", bus.MEM_ADDR, model_addr(blk, k));
      chk("fetch_req_ready", bus.ADDRESS_TO_L2_READY_INSTRUCTION_CACHE, 0);
      chk("fetch_valid", bus.DATA_FROM_L2_VALID_INSTRUCTION_CACHE, 0);
      tick();
    end
    chk("drain_rd_en", bus.MEM_RD_EN, 0);
    chk("drain_valid", bus.DATA_FROM_L2_VALID_INSTRUCTION_CACHE, 0);
    chk("drain_req_ready", bus.ADDRESS_TO_L2_READY_INSTRUCTION_CACHE, 0);
    tick();
    chk("valid_rise", bus.DATA_FROM_L2_VALID_INSTRUCTION_CACHE, 1);
    chk("line", bus.DATA_FROM_L2_INSTRUCTION_CACHE, model_line(blk));
  endtask

  task automatic respond(input logic [25:0] blk, input int delay, input bit keep);
    logic [511:0] l;
    l = model_line(blk);
    for (int i = 0; i < delay; i++) begin
      bus.DATA_FROM_L2_READY_INSTRUCTION_CACHE = 1'b0;
      tick();
      chk("bp_valid", bus.DATA_FROM_L2_VALID_INSTRUCTION_CACHE, 1);
      chk("bp_line", bus.DATA_FROM_L2_INSTRUCTION_CACHE, l);
      chk("bp_req_ready", bus.ADDRESS_TO_L2_READY_INSTRUCTION_CACHE, 0);
    end
    bus.DATA_FROM_L2_READY_INSTRUCTION_CACHE = 1'b1;
    tick();
    chk("hs_valid_clear", bus.DATA_FROM_L2_VALID_INSTRUCTION_CACHE, 0);
    chk("hs_req_ready", bus.ADDRESS_TO_L2_READY_INSTRUCTION_CACHE, 1);
    if (!keep) bus.DATA_FROM_L2_READY_INSTRUCTION_CACHE = 1'b0;
  endtask

  initial begin
    logic [25:0] blk;
    errors = 0;
    checks = 0;
    for (int n = 0; n < int'(MSIZE); n++) mem[n] = 32'h1000_0000 + n;

    // Reset with a request pending: must not be accepted.
    RST = 1'b1;
    bus.ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE = 1'b1;
    bus.ADDRESS_TO_L2_INSTRUCTION_CACHE       = '0;
    bus.DATA_FROM_L2_READY_INSTRUCTION_CACHE  = 1'b0;
    repeat (3) tick();
    chk("rst_rd_en", bus.MEM_RD_EN, 0);
    chk("rst_addr", bus.MEM_ADDR, 0);
    chk("rst_valid", bus.DATA_FROM_L2_VALID_INSTRUCTION_CACHE, 0);
    chk("rst_data", bus.DATA_FROM_L2_INSTRUCTION_CACHE, 0);
    chk("rst_req_ready", bus.ADDRESS_TO_L2_READY_INSTRUCTION_CACHE, 1);
    RST = 1'b0;
    bus.ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE = 1'b0;
    tick();
    chk("post_rst_no_accept", bus.MEM_RD_EN, 0);

    // Basic fetch, block 0.
    issue(26'd0);
    expect_fetch(26'd0);
    chk("basic_word0", bus.DATA_FROM_L2_INSTRUCTION_CACHE[511:480], 32'h1000_0000);
    chk("basic_word15", bus.DATA_FROM_L2_INSTRUCTION_CACHE[31:0], 32'h1000_000F);
    respond(26'd0, 0, 1'b0);

    // Non-zero block with 5 cycles of backpressure.
    issue(26'd3);
    expect_fetch(26'd3);
    chk("blk3_word0", bus.DATA_FROM_L2_INSTRUCTION_CACHE[511:480], 32'h1000_0030);
    respond(26'd3, 5, 1'b0);

    // Back-to-back: block 1 held valid through RESPOND, DATA_READY kept high.
    issue(26'd2);
    expect_fetch(26'd2);
    bus.ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE = 1'b1;
    bus.ADDRESS_TO_L2_INSTRUCTION_CACHE       = 26'd1;
    chk("b2b_wait_ready", bus.ADDRESS_TO_L2_READY_INSTRUCTION_CACHE, 0);
    bus.DATA_FROM_L2_READY_INSTRUCTION_CACHE = 1'b1;
    tick();
    chk("b2b_hs_valid", bus.DATA_FROM_L2_VALID_INSTRUCTION_CACHE, 0);
    chk("b2b_hs_req_ready", bus.ADDRESS_TO_L2_READY_INSTRUCTION_CACHE, 1);
    chk("b2b_not_yet_fetch", bus.MEM_RD_EN, 0);
    tick();
    bus.ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE = 1'b0;
    expect_fetch(26'd1);
    tick();
    chk("ready_high_consume", bus.DATA_FROM_L2_VALID_INSTRUCTION_CACHE, 0);
    chk("ready_high_idle", bus.ADDRESS_TO_L2_READY_INSTRUCTION_CACHE, 1);
    bus.DATA_FROM_L2_READY_INSTRUCTION_CACHE = 1'b0;

    // Reset after word 7 has been issued.
    issue(26'd5);
    for (int k = 0; k < 8; k++) begin
      chk("mid_addr", bus.MEM_ADDR, model_addr(26'd5, k));
      tick();
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("midrst_rd_en", bus.MEM_RD_EN, 0);
    chk("midrst_req_ready", bus.ADDRESS_TO_L2_READY_INSTRUCTION_CACHE, 1);
    chk("midrst_data", bus.DATA_FROM_L2_INSTRUCTION_CACHE, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("midrst_no_valid", bus.DATA_FROM_L2_VALID_INSTRUCTION_CACHE, 0);
      chk("midrst_no_rd", bus.MEM_RD_EN, 0);
    end
    issue(26'd2);
    expect_fetch(26'd2);
    respond(26'd2, 1, 1'b0);

    // Address wrap at the top of the block space.
    issue(26'h3FF_FFFF);
    chk("wrap_first_addr", bus.MEM_ADDR, 10'd1008);
    expect_fetch(26'h3FF_FFFF);
    respond(26'h3FF_FFFF, 0, 1'b0);

    // Random memory contents, blocks and backpressure.
    for (int n = 0; n < int'(MSIZE); n++) mem[n] = $urandom;
    for (int r = 0; r < 6; r++) begin
      blk = 26'($urandom);
      issue(blk);
      expect_fetch(blk);
      respond(blk, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
